// File: rtl/jogo_pkg.sv
// Shared constants, game-state encoding and width helper for the frame scheduler.
package jogo_pkg;

  localparam int H_VIS_DEF         = 640;
  localparam int H_FP_DEF          = 16;
  localparam int H_SYNC_DEF        = 96;
  localparam int H_BP_DEF          = 48;
  localparam int V_VIS_DEF         = 480;
  localparam int V_FP_DEF          = 10;
  localparam int V_SYNC_DEF        = 2;
  localparam int V_BP_DEF          = 33;
  localparam int VIDAS_INI_DEF     = 3;
  localparam int PISCA_QUADROS_DEF = 60;

  localparam int END_W = 19;

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    JOGANDO = 2'd1,
    COLISAO = 2'd2,
    FIM     = 2'd3
  } estado_t;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int largura(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/escalonador_quadro_if.sv
// Video/game bus between the frame scheduler (master) and renderer/controllers (slave).
interface escalonador_quadro_if;
  import jogo_pkg::*;

  logic             pix_ce;
  logic             iniciar;
  logic [1:0]       control;
  logic             colisao;
  logic [END_W-1:0] endereco;
  logic             ativo;
  logic             hsync;
  logic             vsync;
  logic             atualiza;
  logic [1:0]       control_q;
  logic [1:0]       estado;
  logic [1:0]       vidas;

  modport master (
    input  pix_ce, iniciar, control, colisao,
    output endereco, ativo, hsync, vsync, atualiza, control_q, estado, vidas
  );

  modport slave (
    output pix_ce, iniciar, control, colisao,
    input  endereco, ativo, hsync, vsync, atualiza, control_q, estado, vidas
  );
endinterface

// File: rtl/contador_vga.sv
// Horizontal/vertical raster counters with zero-latency sync, active-area and address decode.
module contador_vga
  import jogo_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [END_W-1:0] endereco,
  output logic             ativo,
  output logic             hsync,
  output logic             vsync,
  output logic             quadro
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_W   = largura(H_TOT);
  localparam int V_W   = largura(V_TOT);

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;

  always_comb begin
    // NOTE: hold values are assigned first so every path writes h_d/v_d and no latch is inferred.
    h_d = h_q;
    v_d = v_q;
    if (pix_ce) begin
      if (int'(h_q) == H_TOT - 1) begin
        h_d = '0;
        v_d = (int'(v_q) == V_TOT - 1) ? '0 : v_q + V_W'(1);
      end else begin
        h_d = h_q + H_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling the pre-edge values.
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    ativo    = (int'(h_q) < H_VIS) && (int'(v_q) < V_VIS);
    endereco = ativo ? END_W'(int'(v_q) * H_VIS + int'(h_q)) : '0;
    hsync    = !((int'(h_q) >= H_VIS + H_FP) && (int'(h_q) < H_VIS + H_FP + H_SYNC));
    vsync    = !((int'(v_q) >= V_VIS + V_FP) && (int'(v_q) < V_VIS + V_FP + V_SYNC));
    // Last pixel clock of the last visible line: one strobe per frame.
    quadro   = pix_ce && (int'(h_q) == H_TOT - 1) && (int'(v_q) == V_VIS - 1);
  end

endmodule

// File: rtl/escalonador_quadro.sv
// Frame scheduler: raster timing plus the ESPERA/JOGANDO/COLISAO/FIM game state machine.
module escalonador_quadro
  import jogo_pkg::*;
#(
  parameter int H_VIS         = H_VIS_DEF,
  parameter int H_FP          = H_FP_DEF,
  parameter int H_SYNC        = H_SYNC_DEF,
  parameter int H_BP          = H_BP_DEF,
  parameter int V_VIS         = V_VIS_DEF,
  parameter int V_FP          = V_FP_DEF,
  parameter int V_SYNC        = V_SYNC_DEF,
  parameter int V_BP          = V_BP_DEF,
  parameter int VIDAS_INI     = VIDAS_INI_DEF,
  parameter int PISCA_QUADROS = PISCA_QUADROS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  escalonador_quadro_if.master vid
);

  localparam int CNT_W = largura(PISCA_QUADROS);

  logic             quadro, ativo, borda, acerto;
  estado_t          estado_q, estado_d;
  logic [1:0]       vidas_q, vidas_d;
  logic [1:0]       control_q, control_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             iniciar_q, iniciar_d;

  contador_vga #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_contador (
    .clk     (clk),
    .reset   (reset),
    .pix_ce  (vid.pix_ce),
    .endereco(vid.endereco),
    .ativo   (ativo),
    .hsync   (vid.hsync),
    .vsync   (vid.vsync),
    .quadro  (quadro)
  );

  assign borda  = vid.iniciar && !iniciar_q;
  assign acerto = (estado_q == JOGANDO) && vid.pix_ce && ativo && vid.colisao;

  always_comb begin
    estado_d  = estado_q;
    vidas_d   = vidas_q;
    cnt_d     = cnt_q;
    iniciar_d = vid.iniciar;
    control_d = quadro ? vid.control : control_q;
    // A hit on the frame strobe itself survives the clear and counts for the next frame.
    pend_d    = acerto || (pend_q && !quadro);

    case (estado_q)
      ESPERA: begin
        if (borda) begin
          estado_d = JOGANDO;
          vidas_d  = 2'(VIDAS_INI);
        end
      end
      JOGANDO: begin
        if (quadro && pend_q) begin
          if (vidas_q > 2'd1) begin
            vidas_d  = vidas_q - 2'd1;
            estado_d = COLISAO;
            cnt_d    = '0;
          end else begin
            vidas_d  = '0;
            estado_d = FIM;
          end
        end
      end
      COLISAO: begin
        if (quadro) begin
          if (int'(cnt_q) == PISCA_QUADROS - 1) begin
            estado_d = JOGANDO;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FIM: begin
        vidas_d = '0;
        if (borda) estado_d = ESPERA;
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q  <= ESPERA;
      vidas_q   <= '0;
      control_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      iniciar_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      vidas_q   <= vidas_d;
      control_q <= control_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      iniciar_q <= iniciar_d;
    end
  end

  assign vid.ativo     = ativo;
  assign vid.atualiza  = quadro && (estado_q == JOGANDO);
  assign vid.control_q = control_q;
  assign vid.estado    = estado_q;
  assign vid.vidas     = vidas_q;

endmodule

// File: doc/escalonador_quadro.md
ESCALONADOR_QUADRO -- requirements
Module: escalonador_quadro

Interface
REQ-001 Parameter H_VIS, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths; line total 800.
REQ-003 Parameter V_VIS, default 480, visible lines.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths; frame total 525.
REQ-005 Parameter VIDAS_INI, default 3, lives loaded at game start.
REQ-006 Parameter PISCA_QUADROS, default 60, frames spent in COLISAO.
REQ-007 clk  in  1  single system clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset; clears all state immediately.
REQ-009 pix_ce  in  1  pixel-clock enable; counters advance only on cycles with pix_ce=1; pix_ce tied to 1 is legal.
REQ-010 iniciar  in  1  start button, already synchronous and debounced.
REQ-011 control  in  2  raw player steering input.
REQ-012 colisao  in  1  collision flag from the renderer for the current pixel.
REQ-013 endereco  out  19  linear pixel address v*640+h while ativo=1, else 0.
REQ-014 ativo  out  1  high while h<H_VIS and v<V_VIS.
REQ-015 hsync / vsync  out  1  active-low sync pulses.
REQ-016 atualiza  out  1  one-cycle strobe that advances car and opponent controllers.
REQ-017 control_q  out  2  steering value held stable for one whole frame.
REQ-018 estado  out  2  game state: ESPERA=0, JOGANDO=1, COLISAO=2, FIM=3.
REQ-019 vidas  out  2  lives remaining.

Function
REQ-020 The h counter SHALL count 0..799 on pix_ce and wrap to 0; on wrap, the v counter SHALL count 0..524 and wrap to 0.
REQ-021 ativo, endereco, hsync and vsync SHALL decode the registered counters combinationally, with zero latency relative to the counters.
REQ-022 hsync SHALL be low for h in 656..751; vsync SHALL be low for v in 490..491.
REQ-023 Internal quadro SHALL pulse for exactly one clk cycle per frame: the cycle with pix_ce=1, h=799 and v=479.
REQ-024 control_q SHALL load control on every quadro pulse, in every state.
REQ-025 atualiza SHALL equal quadro AND estado=JOGANDO; it SHALL never be high on two consecutive cycles.
REQ-026 iniciar SHALL be rising-edge detected against a registered copy; only edges act.
REQ-027 ESPERA: on an iniciar edge, go to JOGANDO and load vidas=VIDAS_INI.
REQ-028 JOGANDO: colisao sampled high on a cycle with pix_ce=1 and ativo=1 SHALL set sticky flag pend.
REQ-029 At quadro with pend=1 in JOGANDO: if vidas>1, decrement vidas, go to COLISAO and clear the frame counter; if vidas=1, set vidas=0 and go to FIM.
REQ-030 pend SHALL clear on every quadro; a colisao on the quadro cycle itself SHALL count toward the next frame.
REQ-031 COLISAO: colisao SHALL be ignored; the frame counter SHALL increment per quadro; after PISCA_QUADROS quadro pulses, go to JOGANDO.
REQ-032 FIM: on an iniciar edge, go to ESPERA; vidas SHALL hold 0.
REQ-033 iniciar edges in JOGANDO or COLISAO SHALL be ignored.

Reset
REQ-034 While reset=0: h=v=0 (so ativo=1, endereco=0), hsync=vsync=1, atualiza=0, control_q=0, estado=ESPERA, vidas=0, pend=0, frame counter=0, iniciar history=0.
REQ-035 Reset asserted mid-frame or mid-state SHALL abort immediately; after release, counting SHALL restart at h=0, v=0.

Structure
REQ-036 Package jogo_pkg SHALL hold the timing constants, the estado encoding and VIDAS_INI / PISCA_QUADROS defaults.
REQ-037 Sub-module contador_vga SHALL hold the h/v counters and the sync/ativo/endereco decode; the FSM SHALL stay in escalonador_quadro.

Verification
REQ-038 Reset release, pix_ce=1, 420000 cycles -> quadro period 420000 cycles; hsync low 96 cycles per line; vsync low 1600 cycles per frame.
REQ-039 h=5, v=2 -> endereco=1285 and ativo=1; h=640, v=0 -> endereco=0 and ativo=0.
REQ-040 iniciar pulse in ESPERA -> estado=1, vidas=3; control=2 held mid-frame -> control_q=2 only after the next quadro.
REQ-041 In JOGANDO, colisao high for one active pixel -> at the next quadro vidas=2 and estado=2; 60 quadro pulses later estado=1; no atualiza pulses during COLISAO.
REQ-042 Three collisions -> estado=3, vidas=0; iniciar pulse -> estado=0.
REQ-043 pix_ce toggling 1-of-2 -> frame takes 840000 cycles; reset pulled low mid-line -> all outputs return to REQ-034 values asynchronously.
